// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: two-entry fetch buffer in front of instruction memory,
// with demand fetch on a miss, optional next-word prefetch, and redirect draining.
module inst_fetch_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int PREFETCH_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pcf,
    input  logic              flush,
    output logic [DATA_W-1:0] inst,
    output logic              stall_f,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        DEMAND,
        PREFETCH,
        DRAIN
    } state_t;

    state_t            state, state_nxt;
    logic              req_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    logic [1:0]        valid;
    logic [ADDR_W-1:0] tag  [2];
    logic [DATA_W-1:0] data [2];
    logic              fill_ptr;

    logic [ADDR_W-1:0] pcf_word;
    logic [ADDR_W-1:0] next_addr;
    logic              hit0, hit1, hit;
    logic              victim;
    logic              pf_buffered;
    logic              wr_en;

    // Lookup is purely combinational so a filled word is usable the cycle after its ack.
    always_comb begin
        pcf_word = pcf & ~ADDR_W'(3);
        hit0     = valid[0] && (tag[0] == pcf_word);
        hit1     = valid[1] && (tag[1] == pcf_word);
        hit      = hit0 || hit1;
        stall_f  = !hit;
        if (hit0)      inst = data[0];
        else if (hit1) inst = data[1];
        else           inst = '0;
    end

    // Never evict the word the processor is looking at; otherwise evict the older fill.
    always_comb begin
        if (hit0)      victim = 1'b1;
        else if (hit1) victim = 1'b0;
        else           victim = fill_ptr;
        next_addr   = mem_addr + ADDR_W'(4);
        pf_buffered = valid[~victim] && (tag[~victim] == next_addr);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        req_nxt   = mem_req;
        addr_nxt  = mem_addr;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && !hit) begin
                    req_nxt   = 1'b1;
                    addr_nxt  = pcf_word;
                    state_nxt = DEMAND;
                end
            end
            DEMAND, PREFETCH: begin
                if (flush) begin
                    if (mem_ack) begin
                        req_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else if (mem_ack) begin
                    wr_en = 1'b1;
                    if (state == DEMAND && PREFETCH_EN != 0 && !pf_buffered) begin
                        addr_nxt  = next_addr;
                        state_nxt = PREFETCH;
                    end else begin
                        req_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            valid    <= '0;
            fill_ptr <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_req  <= req_nxt;
            mem_addr <= addr_nxt;
            if (flush) begin
                valid <= '0;
            end else if (wr_en) begin
                valid[victim] <= 1'b1;
                fill_ptr      <= ~victim;
            end
        end
    end

    // NOTE: tag/data storage is not reset; the valid bits alone decide whether it is used.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag[victim]  <= mem_addr;
            data[victim] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a latency-programmable memory responder plus
// a linear sequence of hand-computed checks; memory word at address a is a ^ 32'hDEAD0000.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcf;
    logic        flush;
    logic [31:0] inst;
    logic        stall_f;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        auto_en;
    int          lat;
    logic        force_ack;
    logic [31:0] force_data;
    int          wait_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_unit #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .PREFETCH_EN(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pcf      (pcf),
        .flush    (flush),
        .inst     (inst),
        .stall_f  (stall_f),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Responder: acks a request after lat extra cycles, or fires a forced stray ack.
    always @(negedge clk) begin
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = force_data;
            wait_cnt  = 0;
        end else if (auto_en && mem_req) begin
            if (wait_cnt == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ 32'hDEAD_0000;
                wait_cnt  = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; pcf = 32'h0; flush = 1'b0;
        auto_en = 1'b1; lat = 2; force_ack = 1'b0; force_data = '0;

        // Reset state
        #3;
        check("rst_stall", {31'd0, stall_f}, 32'd1);
        check("rst_inst", inst, 32'h0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        tick(); tick(); #1;
        check("rst_hold_req", {31'd0, mem_req}, 32'd0);

        // Cold fetch of 0x0, ack two cycles after the request
        tick(); rst = 1'b1; #1;
        check("cold_n_stall", {31'd0, stall_f}, 32'd1);
        check("cold_n_req", {31'd0, mem_req}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            check("cold_wait_stall", {31'd0, stall_f}, 32'd1);
            check("cold_wait_req", {31'd0, mem_req}, 32'd1);
            check("cold_wait_addr", mem_addr, 32'h0);
        end
        tick(); #1;
        check("cold_hit_stall", {31'd0, stall_f}, 32'd0);
        check("cold_hit_inst", inst, 32'hDEAD_0000);
        check("cold_pf_req", {31'd0, mem_req}, 32'd1);
        check("cold_pf_addr", mem_addr, 32'h4);
        tick(); tick(); #1;
        check("cold_pf_hold", mem_addr, 32'h4);
        tick(); pcf = 32'h4; #1;
        check("cold_pf_hit_stall", {31'd0, stall_f}, 32'd0);
        check("cold_pf_hit_inst", inst, 32'hDEAD_0004);
        check("cold_idle_req", {31'd0, mem_req}, 32'd0);

        // Flush in IDLE, then sequential stream 0,4,8 with zero-latency memory
        tick(); flush = 1'b1; pcf = 32'h0; #1;
        check("flush_pre_stall", {31'd0, stall_f}, 32'd0);
        tick(); flush = 1'b0; lat = 0; #1;
        check("flush_idle_stall", {31'd0, stall_f}, 32'd1);
        check("flush_idle_noreq", {31'd0, mem_req}, 32'd0);
        tick(); #1;
        check("seq_req0_addr", mem_addr, 32'h0);
        check("seq_req0_req", {31'd0, mem_req}, 32'd1);
        tick(); #1;
        check("seq_hit0_inst", inst, 32'hDEAD_0000);
        check("seq_pf4_addr", mem_addr, 32'h4);
        tick(); pcf = 32'h4; #1;
        check("seq_hit4_stall", {31'd0, stall_f}, 32'd0);
        check("seq_hit4_inst", inst, 32'hDEAD_0004);
        tick(); pcf = 32'h8; #1;
        check("seq_miss8_stall", {31'd0, stall_f}, 32'd1);
        tick(); #1;
        check("seq_miss8_stall2", {31'd0, stall_f}, 32'd1);
        check("seq_req8_addr", mem_addr, 32'h8);
        tick(); #1;
        check("seq_hit8_stall", {31'd0, stall_f}, 32'd0);
        check("seq_hit8_inst", inst, 32'hDEAD_0008);
        check("seq_pfc_addr", mem_addr, 32'hC);
        tick(); pcf = 32'hC; #1;
        check("seq_hitc_inst", inst, 32'hDEAD_000C);
        check("seq_idle_req", {31'd0, mem_req}, 32'd0);

        // Branch flush during prefetch of 0x8, redirect to 0x40
        tick(); pcf = 32'h4; lat = 3; #1;
        check("br_miss4_stall", {31'd0, stall_f}, 32'd1);
        tick(); #1;
        check("br_req4_addr", mem_addr, 32'h4);
        tick(); tick(); tick();
        tick(); #1;
        check("br_hit4_inst", inst, 32'hDEAD_0004);
        check("br_pf8_addr", mem_addr, 32'h8);
        flush = 1'b1; pcf = 32'h40;
        tick(); flush = 1'b0; #1;
        check("br_drain_req", {31'd0, mem_req}, 32'd1);
        check("br_drain_addr", mem_addr, 32'h8);
        check("br_drain_stall", {31'd0, stall_f}, 32'd1);
        tick(); tick();
        tick(); lat = 0; #1;
        check("br_drained_req", {31'd0, mem_req}, 32'd0);
        check("br_drained_stall", {31'd0, stall_f}, 32'd1);
        tick(); #1;
        check("br_req40_req", {31'd0, mem_req}, 32'd1);
        check("br_req40_addr", mem_addr, 32'h40);
        tick(); #1;
        check("br_hit40_inst", inst, 32'hDEAD_0040);
        check("br_pf44_addr", mem_addr, 32'h44);
        pcf = 32'h8; #1;
        check("br_no_hit8_stall", {31'd0, stall_f}, 32'd1);
        check("br_no_hit8_inst", inst, 32'h0);
        tick(); pcf = 32'h44; #1;
        check("br_hit44_inst", inst, 32'hDEAD_0044);

        // Address wrap on prefetch
        tick(); pcf = 32'hFFFF_FFFC; #1;
        check("wrap_miss_stall", {31'd0, stall_f}, 32'd1);
        tick(); #1;
        check("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        check("wrap_hit_inst", inst, 32'h2152_FFFC);
        check("wrap_pf_addr", mem_addr, 32'h0000_0000);
        tick(); pcf = 32'h0; #1;
        check("wrap_pf_hit_inst", inst, 32'hDEAD_0000);

        // Flush coinciding with the demand ack
        tick(); pcf = 32'h80; #1;
        check("fa_miss_stall", {31'd0, stall_f}, 32'd1);
        tick(); flush = 1'b1; #1;
        check("fa_req_addr", mem_addr, 32'h80);
        tick(); flush = 1'b0; auto_en = 1'b0; #1;
        check("fa_stall", {31'd0, stall_f}, 32'd1);
        check("fa_inst", inst, 32'h0);
        check("fa_idle_req", {31'd0, mem_req}, 32'd0);

        // Reset in the middle of a demand, stray acks afterwards
        tick(); #1;
        check("rm_req", {31'd0, mem_req}, 32'd1);
        check("rm_addr", mem_addr, 32'h80);
        rst = 1'b0; force_ack = 1'b1; force_data = 32'h0000_0BAD; #1;
        check("rm_rst_req", {31'd0, mem_req}, 32'd0);
        check("rm_rst_addr", mem_addr, 32'h0);
        check("rm_rst_stall", {31'd0, stall_f}, 32'd1);
        check("rm_rst_inst", inst, 32'h0);
        tick(); rst = 1'b1; #1;
        check("rm_rel_req", {31'd0, mem_req}, 32'd0);
        check("rm_rel_stall", {31'd0, stall_f}, 32'd1);
        tick(); force_ack = 1'b0; #1;
        check("rm_new_req", {31'd0, mem_req}, 32'd1);
        check("rm_new_addr", mem_addr, 32'h80);
        check("rm_new_stall", {31'd0, stall_f}, 32'd1);
        tick(); #1;
        check("rm_hold_req", {31'd0, mem_req}, 32'd1);
        check("rm_hold_stall", {31'd0, stall_f}, 32'd1);
        auto_en = 1'b1;
        tick(); #1;
        check("rm_hit_stall", {31'd0, stall_f}, 32'd0);
        check("rm_hit_inst", inst, 32'hDEAD_0080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
